// File: rtl/bus_responder_regs.sv
// bus_responder_regs: async-strobe bus slave with a 16x32 register file, fixed wait states and BERR on ID writes
module bus_responder_regs #(
  parameter logic [31:0] BASE_ADDR   = 32'h00FF0000,
  parameter int unsigned WAIT_STATES = 2,
  parameter logic [31:0] ID_VALUE    = 32'hF1D6E700
) (
  input  logic        comm_clock,
  input  logic        pin_reset_in,
  input  logic        pin_as,
  input  logic        pin_ds,
  input  logic        pin_rw,
  input  logic [31:0] pin_ad,
  output logic [31:0] ad_out,
  output logic        ad_oe,
  output logic        pin_dsack0,
  output logic        pin_dsack1,
  output logic        pin_berr,
  output logic [15:0] hit_count
);
  typedef enum logic [2:0] {IDLE, ADDR, WAIT_DS, WAIT, ACK, ERR, RELEASE} state_t;
  state_t state, next;
  logic [1:0] as_q, ds_q, rw_q;
  logic as_s, ds_s, rw_s, as_d, dsack_n;
  logic [31:2] addr_q;
  logic [3:0] cnt, idx;
  logic [31:0] regs [15];
  logic hit;
  assign as_s = as_q[1];
  assign ds_s = ds_q[1];
  assign rw_s = rw_q[1];
  assign idx = addr_q[5:2];
  assign hit = addr_q[31:6] == BASE_ADDR[31:6];
  assign pin_dsack0 = dsack_n;
  assign pin_dsack1 = dsack_n;
  always_comb begin
    next = state;
    case (state)
      IDLE:    if (as_d && !as_s) next = ADDR;
      ADDR:    next = hit ? WAIT_DS : IDLE;
      WAIT_DS: next = !ds_s ? WAIT : as_s ? IDLE : WAIT_DS;
      WAIT:    if (cnt == 4'd0) next = (!rw_s && idx == 4'hF) ? ERR : ACK;
      ACK:     next = RELEASE;
      ERR:     next = RELEASE;
      RELEASE: if (as_s && ds_s) next = IDLE;
      default: next = IDLE;
    endcase
  end
  always_ff @(posedge comm_clock) begin
    if (!pin_reset_in) begin
      state <= IDLE;
      as_q <= 2'b11;
      ds_q <= 2'b11;
      rw_q <= 2'b11;
      as_d <= 1'b1;
      addr_q <= '0;
      cnt <= '0;
      dsack_n <= 1'b1;
      pin_berr <= 1'b1;
      ad_oe <= 1'b0;
      ad_out <= '0;
      hit_count <= '0;
      for (int i = 0; i < 15; i++) regs[i] <= '0;
    end else begin
      as_q <= {as_q[0], pin_as};
      ds_q <= {ds_q[0], pin_ds};
      rw_q <= {rw_q[0], pin_rw};
      as_d <= as_s;
      state <= next;
      if (state == IDLE && next == ADDR) addr_q <= pin_ad[31:2];
      if (state == WAIT_DS && next == WAIT) cnt <= 4'(WAIT_STATES);
      else if (state == WAIT) cnt <= cnt - 4'd1;
      // response is registered on the transition edge so DSACK lands WAIT_STATES+2 clocks after ds_s
      if (next == ACK && state == WAIT) begin
        dsack_n <= 1'b0;
        hit_count <= hit_count + 16'd1;
        if (rw_s) begin
          ad_out <= (idx == 4'hF) ? ID_VALUE : regs[idx];
          ad_oe <= 1'b1;
        end else if (idx != 4'hF) regs[idx] <= pin_ad;
      end
      if (next == ERR && state == WAIT) begin
        pin_berr <= 1'b0;
        hit_count <= hit_count + 16'd1;
      end
      if (state == RELEASE && next == IDLE) begin
        dsack_n <= 1'b1;
        pin_berr <= 1'b1;
        ad_oe <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_bus_responder_regs.sv
// tb_bus_responder_regs: random bus cycles against a register-map model, three wait-state variants in parallel
module tb_bus_responder_regs;
  localparam logic [31:0] BASE = 32'h00FF0000;
  localparam logic [31:0] ID = 32'hF1D6E700;
  logic clk = 1'b0;
  logic rst_n, as_n, ds_n, rw;
  logic [31:0] ad;
  logic [31:0] aout [3];
  logic [15:0] hc [3];
  logic [2:0] oe, dk0, dk1, be, rsp;
  int n_vec = 0, n_err = 0;
  int wst [3] = '{2, 0, 5};
  logic [31:0] m_regs [16];
  logic [15:0] m_hits;
  always #5 clk = ~clk;
  bus_responder_regs #(.BASE_ADDR(BASE), .WAIT_STATES(2), .ID_VALUE(ID)) dut (
    .comm_clock(clk), .pin_reset_in(rst_n), .pin_as(as_n), .pin_ds(ds_n), .pin_rw(rw), .pin_ad(ad),
    .ad_out(aout[0]), .ad_oe(oe[0]), .pin_dsack0(dk0[0]), .pin_dsack1(dk1[0]), .pin_berr(be[0]), .hit_count(hc[0]));
  bus_responder_regs #(.BASE_ADDR(BASE), .WAIT_STATES(0), .ID_VALUE(ID)) dut_w0 (
    .comm_clock(clk), .pin_reset_in(rst_n), .pin_as(as_n), .pin_ds(ds_n), .pin_rw(rw), .pin_ad(ad),
    .ad_out(aout[1]), .ad_oe(oe[1]), .pin_dsack0(dk0[1]), .pin_dsack1(dk1[1]), .pin_berr(be[1]), .hit_count(hc[1]));
  bus_responder_regs #(.BASE_ADDR(BASE), .WAIT_STATES(5), .ID_VALUE(ID)) dut_w5 (
    .comm_clock(clk), .pin_reset_in(rst_n), .pin_as(as_n), .pin_ds(ds_n), .pin_rw(rw), .pin_ad(ad),
    .ad_out(aout[2]), .ad_oe(oe[2]), .pin_dsack0(dk0[2]), .pin_dsack1(dk1[2]), .pin_berr(be[2]), .hit_count(hc[2]));
  assign rsp = ~dk0 | ~dk1 | ~be | oe;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic model_reset();
    for (int i = 0; i < 15; i++) m_regs[i] = '0;
    m_regs[15] = ID;
    m_hits = '0;
  endtask
  task automatic check_released(input string tag);
    for (int i = 0; i < 3; i++) check(tag, {31'd0, rsp[i]}, 32'd0);
  endtask
  task automatic run_cycle(input logic r, input logic [31:0] a, input logic [31:0] wd, input bit rst_in_release);
    int lat [3];
    logic h, e;
    logic [3:0] ix;
    h = a[31:6] == BASE[31:6];
    ix = a[5:2];
    e = h && !r && ix == 4'hF;
    @(negedge clk);
    rw = r; ad = a; as_n = 1'b0;
    repeat (4) @(negedge clk);
    ad = r ? $urandom : wd;
    ds_n = 1'b0;
    lat = '{0, 0, 0};
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) if (lat[i] == 0 && rsp[i]) lat[i] = c;
    end
    if (h) begin
      m_hits = m_hits + 16'd1;
      if (!r && ix != 4'hF) m_regs[ix] = wd;
    end
    for (int i = 0; i < 3; i++) check($sformatf("latency_w%0d", wst[i]), lat[i], h ? wst[i] + 4 : 0);
    check("dsack0", {31'd0, dk0[0]}, {31'd0, !(h && !e)});
    check("dsack1", {31'd0, dk1[0]}, {31'd0, !(h && !e)});
    check("berr", {31'd0, be[0]}, {31'd0, !e});
    check("ad_oe", {31'd0, oe[0]}, {31'd0, h && r});
    if (h && r) check("ad_out", aout[0], m_regs[ix]);
    check("hit_count", {16'd0, hc[0]}, {16'd0, m_hits});
    if (rst_in_release) begin
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk); #1;
      check_released("reset_release");
      check("reset_hits", {16'd0, hc[0]}, 32'd0);
      check("reset_ad_out", aout[0], 32'd0);
      @(negedge clk);
      as_n = 1'b1; ds_n = 1'b1; rw = 1'b1;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      repeat (2) @(negedge clk);
    end else begin
      @(negedge clk);
      as_n = 1'b1; ds_n = 1'b1; rw = 1'b1;
      repeat (5) @(negedge clk);
      check_released("release");
    end
  endtask
  task automatic abort_cycle(input logic [31:0] a);
    int seen;
    seen = 0;
    @(negedge clk);
    rw = 1'b1; ad = a; as_n = 1'b0;
    repeat (4) @(negedge clk);
    as_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (rsp != 3'b000) seen++;
    end
    check("abort_quiet", seen, 0);
    check("abort_hits", {16'd0, hc[0]}, {16'd0, m_hits});
  endtask
  initial begin
    logic [31:0] a;
    rst_n = 1'b0; as_n = 1'b1; ds_n = 1'b1; rw = 1'b1; ad = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check_released("reset_state");
    check("reset_hit_count", {16'd0, hc[0]}, 32'd0);
    check("reset_ad_out", aout[0], 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    run_cycle(1'b0, BASE + 32'd8, 32'hDEADBEEF, 0);
    run_cycle(1'b1, BASE + 32'd8, 32'h0, 0);
    run_cycle(1'b1, BASE + 32'd60, 32'h0, 0);
    run_cycle(1'b0, BASE + 32'd60, 32'h12345678, 0);
    run_cycle(1'b1, BASE + 32'd63, 32'h0, 0);
    run_cycle(1'b0, 32'h2020FFFF, 32'hCAFEF00D, 0);
    run_cycle(1'b1, 32'h2020FFFF, 32'h0, 0);
    abort_cycle(BASE + 32'd4);
    for (int k = 0; k < 30; k++) begin
      if ($urandom_range(0, 3) != 0) a = {BASE[31:6], 6'($urandom)};
      else begin
        a = $urandom;
        if (a[31:6] == BASE[31:6]) a[31] = ~a[31];
      end
      run_cycle(1'($urandom_range(0, 1)), a, $urandom, 0);
    end
    run_cycle(1'b1, BASE + 32'd8, 32'h0, 1);
    run_cycle(1'b1, BASE + 32'd8, 32'h0, 0);
    run_cycle(1'b0, BASE + 32'd20, 32'h0BADF00D, 0);
    run_cycle(1'b1, BASE + 32'd20, 32'h0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/bus_responder_regs.md
BUS_RESPONDER_REGS -- requirements
Module: bus_responder_regs

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h00FF0000, base of the decoded window (64-byte aligned).
REQ-002 SHALL have parameter WAIT_STATES, default 2, extra clocks inserted between DS seen and DSACK asserted (range 0..15).
REQ-003 SHALL have parameter ID_VALUE, default 32'hF1D6E700, the read-only contents of register 15.
REQ-004 comm_clock  in  1  sole clock; all logic on rising edge.
REQ-005 pin_reset_in  in  1  reset, synchronous, active-low.
REQ-006 pin_as  in  1  address strobe, active-low, asynchronous to comm_clock.
REQ-007 pin_ds  in  1  data strobe, active-low, asynchronous.
REQ-008 pin_rw  in  1  1=read, 0=write, asynchronous.
REQ-009 pin_ad  in  32  multiplexed address/data bus input.
REQ-010 ad_out  out  32  read data to drive onto the AD bus.
REQ-011 ad_oe  out  1  1 = external buffer drives ad_out onto the AD bus.
REQ-012 pin_dsack0 / pin_dsack1  out  1 each  active-low data-size acknowledge; both low = 32-bit port.
REQ-013 pin_berr  out  1  active-low bus error.
REQ-014 hit_count  out  16  number of completed cycles (ACK or BERR) addressed to this block.

Function
REQ-015 pin_as, pin_ds and pin_rw SHALL each pass through a 2-flop synchronizer; all decisions use the synchronized values (as_s, ds_s, rw_s).
REQ-016 The register file SHALL be 16 x 32-bit, indexed by address bits [5:2]; register 15 SHALL read as ID_VALUE and SHALL NOT be writable.
REQ-017 A cycle hits when pin_ad[31:6] == BASE_ADDR[31:6]; bits [1:0] SHALL be ignored.
REQ-018 The FSM SHALL have states IDLE, ADDR, WAIT_DS, WAIT, ACK, ERR, RELEASE.
REQ-019 IDLE: on as_s falling (1->0), the FSM SHALL sample pin_ad into addr_q in that same cycle and enter ADDR; bus masters hold the address for at least 3 comm_clock periods.
REQ-020 ADDR: on a miss -> IDLE with no outputs asserted (a different target owns the cycle); on a hit -> WAIT_DS.
REQ-021 WAIT_DS: on ds_s==0, load the wait counter with WAIT_STATES and enter WAIT; on as_s==1 before ds_s==0 -> IDLE (aborted cycle, no count).
REQ-022 WAIT: decrement the counter each clock; at 0 enter ACK, or ERR if rw_s==0 and the index is 15; with WAIT_STATES=0, WAIT SHALL last exactly one clock.
REQ-023 ACK entry, write: register[index] <= pin_ad sampled in the transition cycle.
REQ-024 ACK entry, read: ad_out <= register[index] and ad_oe <= 1, both registered on the transition cycle.
REQ-025 ACK: pin_dsack0=pin_dsack1=0; ERR: pin_berr=0 and DSACK held at 1; both states SHALL advance to RELEASE on the next clock, keeping the outputs asserted.
REQ-026 RELEASE: hold DSACK/BERR/ad_oe asserted until as_s==1 and ds_s==1 in the same cycle, then deassert them all on the following edge and return to IDLE.
REQ-027 hit_count SHALL increment by 1 on each ACK or ERR entry and wrap from 16'hFFFF to 0.
REQ-028 The interval from ds_s==0 to DSACK low SHALL be WAIT_STATES+2 clocks.
REQ-029 A new AS falling edge while not in IDLE SHALL be ignored.

Reset
REQ-030 While pin_reset_in==0 at a clock edge, the FSM SHALL go to IDLE and set pin_dsack0=1, pin_dsack1=1, pin_berr=1, ad_oe=0, ad_out=0, hit_count=0, registers 0..14 = 0, and synchronizers = 1; reset asserted mid-cycle SHALL release the bus on that same edge.

Verification
REQ-031 Write 32'hDEADBEEF to BASE_ADDR+8, then read BASE_ADDR+8 -> ad_out=32'hDEADBEEF, ad_oe=1, both DSACKs low, hit_count=2.
REQ-032 Read BASE_ADDR+60 -> ad_out=32'hF1D6E700; write BASE_ADDR+60 -> pin_berr=0, DSACKs stay 1, register 15 unchanged, hit_count increments.
REQ-033 Cycle to 32'h2020FFFF (miss) -> no DSACK, BERR or ad_oe for the whole cycle; hit_count unchanged.
REQ-034 WAIT_STATES=0 and WAIT_STATES=5 -> DSACK falls exactly 2 and 7 clocks after ds_s==0, respectively.
REQ-035 AS deasserted before DS (aborted cycle) -> FSM returns to IDLE, no outputs, no count; reset asserted while in RELEASE -> all strobes released on the same edge, hit_count=0.
